controller_responder: RTL and testbench



---
 rtl/guybox_pkg.sv | 23 ++
 rtl/sync_edge.sv | 44 ++++
 rtl/controller_responder.sv | 120 ++++++++++++
 tb/tb_controller_responder.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/guybox_pkg.sv
// Shared GuyBox definitions: controller button indices and the responder state encoding.
package guybox_pkg;

  localparam int unsigned BTN_A      = 0;
  localparam int unsigned BTN_B      = 1;
  localparam int unsigned BTN_SELECT = 2;
  localparam int unsigned BTN_START  = 3;
  localparam int unsigned BTN_UP     = 4;
  localparam int unsigned BTN_DOWN   = 5;
  localparam int unsigned BTN_LEFT   = 6;
  localparam int unsigned BTN_RIGHT  = 7;

  localparam int unsigned EXTRA_W   = 4;
  localparam int unsigned EXTRA_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } ctrl_resp_state_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-stage synchronizer for an asynchronous pin, with registered level and edge strobes.
module sync_edge #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_in,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_q, sync_d;
  logic level_q, level_d;
  logic rise_q, rise_d;
  logic fall_q, fall_d;

  // Level is delayed one stage so it lines up with the edge strobes.
  always_comb begin
    sync_d  = {sync_q[STAGES-2:0], d_in};
    level_d = sync_q[STAGES-1];
    rise_d  = sync_q[STAGES-1] & ~level_q;
    fall_d  = ~sync_q[STAGES-1] & level_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level = level_q;
  assign rise  = rise_q;
  assign fall  = fall_q;

endmodule

// File: rtl/controller_responder.sv
// Emulated GuyBox controller: answers the host latch/pulse protocol by shifting out a
// button snapshot on data_out, and counts stray pulses after the frame ends.
module controller_responder
  import guybox_pkg::*;
#(
  parameter int unsigned NBITS           = 8,
  parameter int unsigned SYNC_STAGES     = 2,
  parameter bit          DATA_ACTIVE_LOW = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NBITS-1:0]   buttons_in,
  input  logic               latch_in,
  input  logic               pulse_in,
  output logic               data_out,
  output logic               frame_done,
  output logic [EXTRA_W-1:0] extra_pulses
);

  localparam int unsigned CNT_W = $clog2(NBITS + 1);

  logic latch_lvl, latch_rise, latch_fall;
  logic pulse_lvl, pulse_rise, pulse_fall;
  logic unused_sync;

  ctrl_resp_state_t   state_q, state_d;
  logic [NBITS-1:0]   shreg_q, shreg_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [EXTRA_W-1:0] extra_q, extra_d;
  logic               data_out_q, data_out_d;
  logic               frame_done_q, frame_done_d;

  sync_edge #(.STAGES(SYNC_STAGES)) u_latch_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (latch_in),
    .level (latch_lvl),
    .rise  (latch_rise),
    .fall  (latch_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES)) u_pulse_sync (
    .clk   (clk),
    .reset (reset),
    .d_in  (pulse_in),
    .level (pulse_lvl),
    .rise  (pulse_rise),
    .fall  (pulse_fall)
  );

  assign unused_sync = ^{latch_rise, pulse_lvl, pulse_fall};

  // Latch level overrides everything, including a coincident pulse edge.
  always_comb begin
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    extra_d      = extra_q;
    frame_done_d = 1'b0;

    if (latch_lvl) begin
      state_d   = ST_LOAD;
      shreg_d   = buttons_in;
      bit_cnt_d = '0;
      extra_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
        end
        ST_LOAD: begin
          if (latch_fall) begin
            state_d = ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (pulse_rise) begin
            shreg_d   = {1'b0, shreg_q[NBITS-1:1]};
            bit_cnt_d = bit_cnt_q + CNT_W'(1);
            if (bit_cnt_q == CNT_W'(NBITS - 1)) begin
              frame_done_d = 1'b1;
              state_d      = ST_DONE;
            end
          end
        end
        ST_DONE: begin
          if (pulse_rise && (extra_q != EXTRA_W'(EXTRA_MAX))) begin
            extra_d = extra_q + EXTRA_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Shifting fills with 0, so IDLE and DONE naturally present the released level.
    data_out_d = shreg_d[0] ^ DATA_ACTIVE_LOW;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      extra_q      <= '0;
      data_out_q   <= DATA_ACTIVE_LOW;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      extra_q      <= extra_d;
      data_out_q   <= data_out_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign data_out     = data_out_q;
  assign frame_done   = frame_done_q;
  assign extra_pulses = extra_q;

endmodule

// File: tb/tb_controller_responder.sv
// Bench for controller_responder: host-side stimulus with a protocol-level reference model.
module tb_controller_responder;

  localparam int NBITS = 8;

  logic       clk;
  logic       reset;
  logic [7:0] buttons_in;
  logic       latch_in;
  logic       pulse_in;
  logic       data_out;
  logic       frame_done;
  logic [3:0] extra_pulses;

  int checks;
  int errors;

  // Reference model: whether a latch has been seen since reset, the snapshot it took,
  // and how many pulses the host has issued since that latch.
  bit         m_framed;
  logic [7:0] m_snap;
  int         m_pos;

  controller_responder dut (
    .clk          (clk),
    .reset        (reset),
    .buttons_in   (buttons_in),
    .latch_in     (latch_in),
    .pulse_in     (pulse_in),
    .data_out     (data_out),
    .frame_done   (frame_done),
    .extra_pulses (extra_pulses)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic exp_data();
    if (m_framed && m_pos < NBITS) return ~m_snap[m_pos];
    return 1'b1;
  endfunction

  function automatic int exp_extra();
    int n;
    if (!m_framed || m_pos <= NBITS) return 0;
    n = m_pos - NBITS;
    return (n > 15) ? 15 : n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Latch high for 10 cycles then low; optionally raise pulse on the same edge as latch.
  task automatic latch_frame(input logic [7:0] b, input bit with_pulse);
    buttons_in = b;
    latch_in   = 1'b1;
    if (with_pulse) pulse_in = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk("frame_done_latch", 8'(frame_done), 8'h00);
      if (c == 6) chk("extra_cleared", 8'(extra_pulses), 8'h00);
    end
    latch_in = 1'b0;
    pulse_in = 1'b0;
    m_framed = 1'b1;
    m_snap   = b;
    m_pos    = 0;
    for (int c = 1; c <= 6; c++) begin
      tick();
      chk("frame_done_unlatch", 8'(frame_done), 8'h00);
    end
    chk("data_bit0", 8'(data_out), 8'(exp_data()));
  endtask

  task automatic pulse_once(input int hi, input int lo);
    bit will_done;
    will_done = m_framed && (m_pos == NBITS - 1);
    pulse_in  = 1'b1;
    for (int c = 1; c <= hi; c++) begin
      tick();
      chk("frame_done_hi", 8'(frame_done), 8'((will_done && c == 4) ? 1 : 0));
    end
    if (m_framed) m_pos++;
    chk("data_after_rise", 8'(data_out), 8'(exp_data()));
    chk("extra_after_rise", 8'(extra_pulses), 8'(exp_extra()));
    pulse_in = 1'b0;
    for (int c = 1; c <= lo; c++) begin
      tick();
      chk("frame_done_lo", 8'(frame_done), 8'h00);
    end
    chk("data_after_fall", 8'(data_out), 8'(exp_data()));
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    #1;
    chk("rst_data", 8'(data_out), 8'h01);
    chk("rst_frame_done", 8'(frame_done), 8'h00);
    chk("rst_extra", 8'(extra_pulses), 8'h00);
    m_framed = 1'b0;
    m_pos    = 0;
    m_snap   = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    reset      = 1'b0;
    buttons_in = 8'h00;
    latch_in   = 1'b0;
    pulse_in   = 1'b0;
    m_framed   = 1'b0;
    m_pos      = 0;
    m_snap     = 8'h00;
    tick();

    // Power-on reset
    do_reset();

    // Pulses before any latch are ignored
    for (int i = 0; i < 3; i++) pulse_once(10, 10);

    // Directed frame 1000_0001, then three extra pulses, then a clearing latch
    latch_frame(8'b1000_0001, 1'b0);
    for (int i = 0; i < NBITS; i++) pulse_once(10, 10);
    for (int i = 0; i < 3; i++) pulse_once(10, 10);
    chk("extra_is_3", 8'(extra_pulses), 8'h03);
    latch_frame(8'h5A, 1'b0);
    chk("extra_cleared_after", 8'(extra_pulses), 8'h00);

    // Abort mid-frame with a fresh latch and new buttons
    for (int i = 0; i < 4; i++) pulse_once(10, 10);
    latch_frame(8'h0F, 1'b0);
    for (int i = 0; i < NBITS; i++) pulse_once(10, 10);

    // Latch and pulse rising together mid-frame: latch wins, count restarts
    latch_frame(8'hC3, 1'b0);
    for (int i = 0; i < 2; i++) pulse_once(10, 10);
    latch_frame(8'h96, 1'b1);
    for (int i = 0; i < NBITS; i++) pulse_once(10, 10);

    // Reset while bit 3 is on the line, then a clean frame
    latch_frame(8'hA5, 1'b0);
    for (int i = 0; i < 3; i++) pulse_once(10, 10);
    pulse_in = 1'b1;
    tick();
    do_reset();
    pulse_in = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    latch_frame(8'h3C, 1'b0);
    for (int i = 0; i < NBITS; i++) pulse_once(10, 10);

    // Randomized frames: random buttons, timing, post-latch button churn and extra pulses
    for (int f = 0; f < 6; f++) begin
      int np;
      latch_frame(8'($urandom), 1'b0);
      buttons_in = 8'($urandom);
      np = NBITS + int'($urandom_range(0, 18));
      for (int i = 0; i < np; i++) begin
        pulse_once(int'($urandom_range(5, 12)), int'($urandom_range(4, 12)));
        if (i == 2) buttons_in = 8'($urandom);
      end
      chk("extra_random", 8'(extra_pulses), 8'(exp_extra()));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
